// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the multi-read RAM with its clear engine.
package sync_ram_pkg;

   typedef enum logic [1:0] {INIT, RUN, CLEAR} ram_state_t;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   function automatic int num_lanes(input int d_width);
      return d_width / 8;
   endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear engine: owns the array for one full sweep after reset or on a clr request.
module ram_clr_ctrl
   import sync_ram_pkg::*;
#(
   parameter int a_width = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   output logic               busy,
   output logic               clr_we,
   output logic [a_width-1:0] clr_addr
);

   ram_state_t         state_q;
   logic [a_width-1:0] ptr_q;
   logic               busy_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= INIT;
         ptr_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            INIT, CLEAR: begin
               if (ptr_q == '1) begin
                  state_q <= RUN;
                  ptr_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            RUN: begin
               if (clr) begin
                  state_q <= CLEAR;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= INIT;
               ptr_q   <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   // The sweep writes exactly in the cycles where busy is high.
   assign busy     = busy_q;
   assign clr_we   = busy_q;
   assign clr_addr = ptr_q;

endmodule

// File: rtl/sync_ram_multi_rw_clr.sv
// Single-write, multi-read synchronous RAM with byte enables, read-during-write
// selection, optional output register and a hardware clear sweep.
module sync_ram_multi_rw_clr
   import sync_ram_pkg::*;
#(
   parameter int                 num_out  = 4,
   parameter int                 d_width  = 16,
   parameter int                 a_width  = 4,
   parameter int                 out_reg  = 0,
   parameter int                 rdw_mode = RDW_OLD,
   parameter logic [d_width-1:0] clr_val  = '0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            clr,
   output logic                            busy,
   input  logic                            we,
   input  logic [num_lanes(d_width)-1:0]   be,
   input  logic [a_width-1:0]              address_w,
   input  logic [d_width-1:0]              data_in,
   input  logic [num_out-1:0]              re,
   input  logic [a_width-1:0]              address_r [num_out],
   output logic [d_width-1:0]              data_out  [num_out],
   output logic [num_out-1:0]              valid
);

   localparam int lanes = num_lanes(d_width);
   localparam int depth = 2**a_width;

   logic [d_width-1:0] mem [depth];

   logic               clr_we;
   logic [a_width-1:0] clr_addr;
   logic               user_we;
   logic               mem_we;
   logic [a_width-1:0] wr_addr;
   logic [d_width-1:0] wr_data;
   logic [d_width-1:0] merged;
   logic [d_width-1:0] rd_word    [num_out];
   logic [d_width-1:0] s1_data_q  [num_out];
   logic [num_out-1:0] s1_valid_q;

   ram_clr_ctrl #(.a_width(a_width)) u_clr_ctrl (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign user_we = we && !busy && (be != '0);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      merged = mem[address_w];
      for (int k = 0; k < lanes; k++) begin
         if (be[k]) merged[8*k +: 8] = data_in[8*k +: 8];
      end
   end

   always_comb begin
      mem_we  = clr_we || user_we;
      wr_addr = clr_we ? clr_addr : address_w;
      wr_data = clr_we ? clr_val  : merged;
      for (int i = 0; i < num_out; i++) begin
         rd_word[i] = mem[address_r[i]];
         if (rdw_mode == RDW_NEW && user_we && address_r[i] == address_w) rd_word[i] = merged;
      end
   end

   // NOTE: the array has no reset; the INIT sweep is what gives it defined contents.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < num_out; i++) s1_data_q[i] <= '0;
         s1_valid_q <= '0;
      end else begin
         for (int i = 0; i < num_out; i++) begin
            s1_valid_q[i] <= re[i] && !busy;
            if (re[i] && !busy) s1_data_q[i] <= rd_word[i];
         end
      end
   end

   generate
      if (out_reg != 0) begin : g_out_reg
         logic [d_width-1:0] s2_data_q [num_out];
         logic [num_out-1:0] s2_valid_q;

         // Drains independently of busy so reads issued before a clear still land.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < num_out; i++) s2_data_q[i] <= '0;
               s2_valid_q <= '0;
            end else begin
               s2_valid_q <= s1_valid_q;
               for (int i = 0; i < num_out; i++) begin
                  if (s1_valid_q[i]) s2_data_q[i] <= s1_data_q[i];
               end
            end
         end

         assign data_out = s2_data_q;
         assign valid    = s2_valid_q;
      end else begin : g_no_out_reg
         assign data_out = s1_data_q;
         assign valid    = s1_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_ram_multi_rw_clr.sv
// Randomised and directed bench for sync_ram_multi_rw_clr; three configurations
// share one stimulus stream and are compared against an array-based reference.
module tb_sync_ram_multi_rw_clr;

   localparam int NO    = 4;
   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int NB    = 2;
   localparam int DEPTH = 16;
   localparam int NCFG  = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          clr;
   logic          we;
   logic [NB-1:0] be;
   logic [AW-1:0] address_w;
   logic [DW-1:0] data_in;
   logic [NO-1:0] re;
   logic [AW-1:0] address_r [NO];

   logic          busy0, busy1, busy2;
   logic [NO-1:0] valid0, valid1, valid2;
   logic [DW-1:0] dout0 [NO];
   logic [DW-1:0] dout1 [NO];
   logic [DW-1:0] dout2 [NO];

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // cfg0: latency 1, old data, clear to 0; cfg1: latency 2, old data, clear to BEEF;
   // cfg2: latency 1, forwarded data, clear to BEEF.
   sync_ram_multi_rw_clr #(.num_out(NO), .d_width(DW), .a_width(AW), .out_reg(0), .rdw_mode(0),
                           .clr_val(16'h0000)) dut0 (
      .clk(clk), .reset(reset), .clr(clr), .busy(busy0), .we(we), .be(be), .address_w(address_w),
      .data_in(data_in), .re(re), .address_r(address_r), .data_out(dout0), .valid(valid0));

   sync_ram_multi_rw_clr #(.num_out(NO), .d_width(DW), .a_width(AW), .out_reg(1), .rdw_mode(0),
                           .clr_val(16'hBEEF)) dut1 (
      .clk(clk), .reset(reset), .clr(clr), .busy(busy1), .we(we), .be(be), .address_w(address_w),
      .data_in(data_in), .re(re), .address_r(address_r), .data_out(dout1), .valid(valid1));

   sync_ram_multi_rw_clr #(.num_out(NO), .d_width(DW), .a_width(AW), .out_reg(0), .rdw_mode(1),
                           .clr_val(16'hBEEF)) dut2 (
      .clk(clk), .reset(reset), .clr(clr), .busy(busy2), .we(we), .be(be), .address_w(address_w),
      .data_in(data_in), .re(re), .address_r(address_r), .data_out(dout2), .valid(valid2));

   function automatic bit cfg_out_reg(input int c);
      return c == 1;
   endfunction

   function automatic bit cfg_fwd(input int c);
      return c == 2;
   endfunction

   function automatic logic [DW-1:0] cfg_clr(input int c);
      return (c == 0) ? 16'h0000 : 16'hBEEF;
   endfunction

   // Reference model state
   logic [DW-1:0] m_mem    [NCFG][DEPTH];
   bit            m_busy   [NCFG];
   int            m_ptr    [NCFG];
   logic [DW-1:0] m_pend_d [NCFG][NO];
   bit            m_pend_v [NCFG][NO];
   logic [DW-1:0] m_out_d  [NCFG][NO];
   bit            m_out_v  [NCFG][NO];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCFG; c++) begin
         m_busy[c] = 1'b1;
         m_ptr[c]  = 0;
         for (int i = 0; i < NO; i++) begin
            m_pend_d[c][i] = '0;
            m_pend_v[c][i] = 1'b0;
            m_out_d[c][i]  = '0;
            m_out_v[c][i]  = 1'b0;
         end
      end
   endtask

   // One rising edge of behaviour, from the pre-edge inputs and model state.
   task automatic model_step();
      logic [DW-1:0] merged;
      logic [DW-1:0] rd;
      for (int c = 0; c < NCFG; c++) begin
         merged = m_mem[c][address_w];
         for (int k = 0; k < NB; k++) if (be[k]) merged[8*k +: 8] = data_in[8*k +: 8];
         for (int i = 0; i < NO; i++) begin
            if (cfg_out_reg(c)) begin
               if (m_pend_v[c][i]) m_out_d[c][i] = m_pend_d[c][i];
               m_out_v[c][i]  = m_pend_v[c][i];
               m_pend_v[c][i] = 1'b0;
            end else begin
               m_out_v[c][i] = 1'b0;
            end
         end
         if (m_busy[c]) begin
            m_mem[c][m_ptr[c]] = cfg_clr(c);
            m_ptr[c]++;
            if (m_ptr[c] == DEPTH) begin
               m_ptr[c]  = 0;
               m_busy[c] = 1'b0;
            end
         end else begin
            for (int i = 0; i < NO; i++) begin
               if (re[i]) begin
                  rd = (cfg_fwd(c) && we && address_r[i] == address_w) ? merged : m_mem[c][address_r[i]];
                  if (cfg_out_reg(c)) begin
                     m_pend_d[c][i] = rd;
                     m_pend_v[c][i] = 1'b1;
                  end else begin
                     m_out_d[c][i] = rd;
                     m_out_v[c][i] = 1'b1;
                  end
               end
            end
            if (we) m_mem[c][address_w] = merged;
            if (clr) m_busy[c] = 1'b1;
         end
      end
   endtask

   task automatic check_cfg(input int c, input logic b, input logic [NO-1:0] v,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic [DW-1:0] d2, input logic [DW-1:0] d3);
      logic [DW-1:0] d [NO];
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      check($sformatf("cfg%0d busy", c), {31'b0, b}, {31'b0, m_busy[c]});
      for (int i = 0; i < NO; i++) begin
         check($sformatf("cfg%0d valid[%0d]", c, i), {31'b0, v[i]}, {31'b0, m_out_v[c][i]});
         check($sformatf("cfg%0d data_out[%0d]", c, i), {16'b0, d[i]}, {16'b0, m_out_d[c][i]});
      end
   endtask

   task automatic check_all();
      check_cfg(0, busy0, valid0, dout0[0], dout0[1], dout0[2], dout0[3]);
      check_cfg(1, busy1, valid1, dout1[0], dout1[1], dout1[2], dout1[3]);
      check_cfg(2, busy2, valid2, dout2[0], dout2[1], dout2[2], dout2[3]);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      clr = 1'b0; we = 1'b0; be = '0; address_w = '0; data_in = '0; re = '0;
      for (int i = 0; i < NO; i++) address_r[i] = '0;
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
      we = 1'b1; address_w = a; data_in = d; be = b;
   endtask

   task automatic count_busy(input string tag);
      int cnt;
      cnt = 0;
      for (int n = 0; n < 24; n++) begin
         if (busy1) cnt++;
         tick();
      end
      check(tag, cnt, 16);
   endtask

   task automatic read_all_addresses();
      for (int a = 0; a < DEPTH; a++) begin
         idle();
         re = '1;
         for (int i = 0; i < NO; i++) address_r[i] = AW'(a);
         tick();
      end
      idle();
      tick();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      model_reset();
      for (int i = 0; i < NB; i++) m_mem[0][i] = 'x;
      @(negedge clk);
      @(negedge clk);
      check_all();
      reset = 1'b0;

      count_busy("busy length after reset");
      read_all_addresses();

      // Byte-lane merge on address 3
      write(4'd3, 16'hA5C3, 2'b01); tick();
      write(4'd3, 16'h7E00, 2'b10); tick();
      idle(); re = 4'b0001; address_r[0] = 4'd3; tick();
      check("byte merge cfg0", {16'b0, dout0[0]}, 32'h7EC3);
      idle(); tick();
      check("byte merge cfg1", {16'b0, dout1[0]}, 32'h7EC3);

      // Read during write on address 5
      write(4'd5, 16'h1111, 2'b11); tick();
      write(4'd5, 16'h2222, 2'b11); re = 4'b0100; address_r[2] = 4'd5; tick();
      check("rdw old cfg0", {16'b0, dout0[2]}, 32'h1111);
      check("rdw new cfg2", {16'b0, dout2[2]}, 32'h2222);
      idle(); write(4'd5, 16'h1111, 2'b11); tick();
      write(4'd5, 16'h33FF, 2'b01); re = 4'b0100; address_r[2] = 4'd5; tick();
      check("rdw partial cfg2", {16'b0, dout2[2]}, 32'h11FF);
      check("rdw partial cfg0", {16'b0, dout0[2]}, 32'h1111);

      // Partial read enables with duplicate addresses
      idle();
      re = 4'b1011;
      address_r[0] = 4'd0; address_r[1] = 4'd7; address_r[2] = 4'd7; address_r[3] = 4'd15;
      tick();
      check("partial re valid cfg0", {28'b0, valid0}, 32'hB);
      idle(); tick();
      check("partial re valid cfg1", {28'b0, valid1}, 32'hB);

      // Clear request, dropped write while busy, ignored second clr
      idle(); clr = 1'b1; tick(); idle();
      begin
         int cnt;
         cnt = 0;
         for (int n = 0; n < 24; n++) begin
            idle();
            if (busy1) cnt++;
            if (n == 3) write(4'd6, 16'hABCD, 2'b11);
            if (n == 8) clr = 1'b1;
            tick();
         end
         check("busy length after clr", cnt, 16);
      end
      idle(); re = 4'b0001; address_r[0] = 4'd6; tick();
      check("dropped write cfg2", {16'b0, dout2[0]}, 32'hBEEF);
      read_all_addresses();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         idle();
         we        = ($urandom_range(0, 2) != 0);
         be        = NB'($urandom_range(0, 3));
         address_w = AW'($urandom_range(0, 15));
         data_in   = DW'($urandom);
         re        = NO'($urandom);
         clr       = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < NO; i++)
            address_r[i] = ($urandom_range(0, 2) == 0) ? address_w : AW'($urandom_range(0, 15));
         tick();
      end
      idle();
      for (int n = 0; n < 20; n++) tick();

      // Reset in the middle of a sweep
      read_all_addresses();
      clr = 1'b1; tick(); idle();
      for (int n = 0; n < 9; n++) tick();
      reset = 1'b1;
      model_reset();
      #1;
      check_all();
      check("reset valid cfg1", {28'b0, valid1}, 32'h0);
      check("reset data cfg2", {16'b0, dout2[0]}, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      count_busy("busy length after mid-sweep reset");
      read_all_addresses();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_ram_multi_rw_clr.md
Name: sync_ram_multi_rw_clr

Overview:
- Parametrised successor of the single-write, multi-read synchronous RAM used across the design.
- Adds per-lane byte write enables, per-port read enables with valid flags, and a selectable read-during-write mode (old data or forwarded new data).
- Adds an optional output pipeline stage and a hardware clear engine that sweeps the whole array after reset or on request.
- Used as shared lookup/line storage read by several pixel/datapath consumers in parallel.

Parameters:
- num_out, 4, number of independent read ports (>=1)
- d_width, 16, word width in bits; must be a multiple of 8
- a_width, 4, address width; depth = 2**a_width
- out_reg, 0, 0: read latency 1 cycle; 1: extra output register, latency 2 cycles
- rdw_mode, 0, 0: same-address read during write returns old word; 1: returns the byte-merged new word
- clr_val, 0, d_width-bit value written to every word by the clear engine

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- clr  in  1  single-cycle request to clear the whole array
- busy  out  1  high while the clear engine owns the array
- we  in  1  write enable
- be  in  d_width/8  byte enables, bit k qualifies data_in[8k+7:8k]
- address_w  in  a_width  write address
- data_in  in  d_width  write data
- re  in  num_out  per-port read enable
- address_r  in  [num_out-1:0] x a_width  per-port read address (unpacked array)
- data_out  out  [num_out-1:0] x d_width  per-port read data (unpacked array)
- valid  out  num_out  per-port flag: data_out[i] holds a fresh read result

Behaviour:
- Reset:
  - data_out all zero; valid all zero; busy = 1.
  - Clear pointer = 0; FSM = INIT.
  - Memory contents are not reset directly; the INIT sweep clears them.
- FSM states: INIT, RUN, CLEAR.
  - INIT/CLEAR: each cycle write clr_val to mem[ptr], then ptr++.
  - When ptr == 2**a_width-1 is written, go to RUN and reset ptr to 0.
  - busy = 1 in INIT and CLEAR, 0 in RUN (registered). Exactly 2**a_width busy cycles after reset release or after clr acceptance.
  - RUN + clr=1: go to CLEAR next cycle; busy rises the cycle after clr.
  - clr while busy is ignored; no restart or extension.
  - reset asserted mid-sweep: sweep restarts at address 0 from INIT.
- Writes (RUN only):
  - mem[address_w] byte k <= data_in byte k where be[k]=1; other bytes are kept.
  - we with be=0 has no effect.
  - we is ignored while busy; the user write is dropped, not queued.
- Reads (RUN only):
  - For each i with re[i]=1 at edge N: data_out[i] is updated at edge N+1 (out_reg=0) or N+2 (out_reg=1), with valid[i]=1 in the same cycle.
  - Ports with re[i]=0: data_out[i] holds its value, valid[i]=0.
  - All ports are independent; identical addresses on several ports are legal.
- Read during write, same address, same edge:
  - rdw_mode=0: returns the pre-write word.
  - rdw_mode=1: returns the merged word (enabled new bytes, old bytes elsewhere).
  - Different addresses: no interaction.
- While busy:
  - re is ignored; valid=0; data_out holds.
  - out_reg=1: the pipeline stage still drains reads issued before busy rose.
- The CLEAR write and a same-cycle clr edge case: the clr arriving in the last INIT cycle is ignored (busy still 1).

Decomposition:
- Package sync_ram_pkg:
  - typedef enum logic [1:0] {INIT, RUN, CLEAR} ram_state_t
  - constants RDW_OLD=0, RDW_NEW=1
  - function computing the number of byte lanes (d_width/8)
- Sub-module ram_clr_ctrl: FSM plus pointer, outputs busy, clr_we, clr_addr.
  - Top level muxes the clear write over the user write port and holds the array, read ports, forwarding and output pipeline.

Test Plan (a_width=4, d_width=16, num_out=4 unless noted):
- Reset release -> busy=1 for exactly 16 cycles; afterwards reads of addr 0..15 on all ports return 0x0000 with valid one cycle after re.
- Write 0xA5C3 to addr 3 with be=2'b01, then be=2'b10 with data 0x7E00 -> read addr 3 = 0x7EC3.
- rdw_mode=0: mem[5]=0x1111, write 0x2222 to addr 5 while port 2 reads addr 5 -> 0x1111; repeat with rdw_mode=1 -> 0x2222; be=2'b01 with data 0x33FF -> 0x11FF.
- Four ports read addr 0, 7, 7, 15 with re=4'b1011 -> valid=4'b1011 next cycle; port 2 data_out and valid unchanged/0. With out_reg=1 the same results appear one cycle later.
- clr pulse in RUN, with clr_val=0xBEEF -> busy high 16 cycles starting the cycle after clr; a write during busy is dropped; all addresses read 0xBEEF afterwards; a second clr mid-sweep does not lengthen busy.
- Assert reset at sweep address 9 -> outputs zero immediately; after release busy lasts the full 16 cycles and the sweep restarts at address 0.
